// File: rtl/serial_operand_shifter.sv
// serial_operand_shifter
// Parallel-in/serial-out operand feeder for a bit-serial adder. Two WIDTH-bit
// operands are captured on a start strobe and then presented one LSB-first bit
// pair per clock. The block also drives the carry flip-flop enable (bit_valid)
// and a carry-clear strobe that accompanies bit 0. A one-cycle done pulse
// follows the last bit.
//
// Optional feature (macro SERIAL_SHIFTER_RECIRC_EN):
//   defined   - the shift registers rotate right, so the loaded operands are
//               back in place after the final bit.
//   undefined - the shift registers zero-fill and are empty after the final bit.
// The serial bit streams are the same in both builds.
//
// Parameters:
//   WIDTH - operand width, 1..15.
//   CNT_W - bit-index counter width, with 2**CNT_W > WIDTH.

`default_nettype none

module serial_operand_shifter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             carry_clr,
    output logic [CNT_W-1:0] bit_idx,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_sr_q,
    output logic [WIDTH-1:0] b_sr_q
);

    // Index of the final bit; the counter wraps back to zero from here.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [WIDTH-1:0] r_aSr;
    logic [WIDTH-1:0] r_bSr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_load;
    logic             w_lastBit;
    logic [WIDTH-1:0] w_aShifted;
    logic [WIDTH-1:0] w_bShifted;

    // A new operation may only begin from IDLE or DONE; start is ignored while shifting.
    assign w_load    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_lastBit = (r_cnt == LAST_IDX);

`ifdef SERIAL_SHIFTER_RECIRC_EN
    // Rotate right so bit 0 re-enters at the MSB; written with shifts so WIDTH=1 is legal.
    assign w_aShifted = (r_aSr >> 1) | (r_aSr << (WIDTH - 1));
    assign w_bShifted = (r_bSr >> 1) | (r_bSr << (WIDTH - 1));
`else
    // Zero-fill shift; the registers drain to zero over one operation.
    assign w_aShifted = r_aSr >> 1;
    assign w_bShifted = r_bSr >> 1;
`endif

    // State register; reset wins over any concurrent start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: IDLE waits for start, SHIFT runs WIDTH cycles, DONE may chain straight into a new load.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_lastBit) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_nextState = ST_SHIFT;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Operand shift registers and bit counter: load on an accepted start, shift once per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aSr <= '0;
            r_bSr <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_aSr <= a_in;
            r_bSr <= b_in;
            r_cnt <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_aSr <= w_aShifted;
            r_bSr <= w_bShifted;
            if (w_lastBit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Moore output decode; everything idles low outside the state that drives it.
    always_comb begin
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        bit_valid = 1'b0;
        carry_clr = 1'b0;
        bit_idx   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                a_bit     = r_aSr[0];
                b_bit     = r_bSr[0];
                bit_idx   = r_cnt;
                carry_clr = (r_cnt == '0);
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign a_sr_q = r_aSr;
    assign b_sr_q = r_bSr;

endmodule

`default_nettype wire

// File: tb/tb_serial_operand_shifter.sv
// tb_serial_operand_shifter
// Directed bench for serial_operand_shifter. The main instance uses WIDTH=4.
// A second instance uses WIDTH=1 and covers the single-bit case. Expected
// shift-register contents after done depend on SERIAL_SHIFTER_RECIRC_EN.

module tb_serial_operand_shifter;

`ifdef SERIAL_SHIFTER_RECIRC_EN
    localparam bit RECIRC = 1'b1;
`else
    localparam bit RECIRC = 1'b0;
`endif

    logic       clk;
    logic       reset;

    // WIDTH=4 instance
    logic       start;
    logic [3:0] aIn;
    logic [3:0] bIn;
    logic       aBit, bBit, bitValid, carryClr, busy, done;
    logic [3:0] bitIdx;
    logic [3:0] aSrQ, bSrQ;

    // WIDTH=1 instance
    logic       start1;
    logic [0:0] aIn1;
    logic [0:0] bIn1;
    logic       aBit1, bBit1, bitValid1, carryClr1, busy1, done1;
    logic [3:0] bitIdx1;
    logic [0:0] aSrQ1, bSrQ1;

    int vectors;
    int miscompares;

    serial_operand_shifter #(.WIDTH(4), .CNT_W(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (aIn),
        .b_in      (bIn),
        .a_bit     (aBit),
        .b_bit     (bBit),
        .bit_valid (bitValid),
        .carry_clr (carryClr),
        .bit_idx   (bitIdx),
        .busy      (busy),
        .done      (done),
        .a_sr_q    (aSrQ),
        .b_sr_q    (bSrQ)
    );

    serial_operand_shifter #(.WIDTH(1), .CNT_W(4)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .a_in      (aIn1),
        .b_in      (bIn1),
        .a_bit     (aBit1),
        .b_bit     (bBit1),
        .bit_valid (bitValid1),
        .carry_clr (carryClr1),
        .bit_idx   (bitIdx1),
        .busy      (busy1),
        .done      (done1),
        .a_sr_q    (aSrQ1),
        .b_sr_q    (bSrQ1)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held with start asserted for two cycles: nothing may start, all outputs low.
    task automatic test_reset();
        logic [9:0] obs;
        reset = 1'b1;
        start = 1'b1;  aIn = 4'b1011;  bIn = 4'b0110;
        start1 = 1'b1; aIn1 = 1'b1;    bIn1 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            obs = {busy, bitValid, carryClr, done, aBit, bBit, bitIdx};
            vectors++;
            if (obs !== 10'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %b want %b", c, obs, 10'b0);
            end
            vectors++;
            if ({aSrQ, bSrQ} !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL reset_sr cycle %0d: got %h want 00", c, {aSrQ, bSrQ});
            end
            vectors++;
            if ({busy1, bitValid1, done1} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL reset_w1 cycle %0d: got %b want 000", c, {busy1, bitValid1, done1});
            end
        end
        reset = 1'b0;
        start = 1'b0;  aIn = 4'b0;  bIn = 4'b0;
        start1 = 1'b0; aIn1 = 1'b0; bIn1 = 1'b0;
        tick();
        vectors++;
        if ({busy, bitValid, done} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got %b want 000", {busy, bitValid, done});
        end
    endtask

    // Basic operation 1011/0110, with an optional ignored start pulse mid-shift.
    task automatic test_basic(input bit pokeStart);
        logic [3:0] aExp;
        logic [3:0] bExp;
        logic [9:0] obs;
        logic [9:0] exp;
        int         validCount;
        aExp = 4'b1011;
        bExp = 4'b0110;
        validCount = 0;
        start = 1'b1; aIn = aExp; bIn = bExp;
        tick();
        start = 1'b0; aIn = 4'b0; bIn = 4'b0;
        vectors++;
        if ({aSrQ, bSrQ} !== {aExp, bExp}) begin
            miscompares++;
            $display("[TB] FAIL load_sr: got %b_%b want %b_%b", aSrQ, bSrQ, aExp, bExp);
        end
        for (int i = 0; i < 4; i++) begin
            obs = {busy, bitValid, carryClr, done, aBit, bBit, bitIdx};
            exp = {1'b1, 1'b1, (i == 0), 1'b0, aExp[i], bExp[i], 4'(i)};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("[TB] FAIL shift_bit%0d: got %b want %b", i, obs, exp);
            end
            if (bitValid === 1'b1) validCount++;
            if (pokeStart && i == 1) begin
                start = 1'b1; aIn = 4'b0000; bIn = 4'b1111;
            end else begin
                start = 1'b0; aIn = 4'b0; bIn = 4'b0;
            end
            tick();
        end
        start = 1'b0; aIn = 4'b0; bIn = 4'b0;
        obs = {busy, bitValid, carryClr, done, aBit, bBit, bitIdx};
        exp = 10'b0001_00_0000;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL done_cycle: got %b want %b", obs, exp);
        end
        exp[9:0] = RECIRC ? {2'b00, aExp, bExp} : 10'b0;
        vectors++;
        if ({2'b00, aSrQ, bSrQ} !== exp) begin
            miscompares++;
            $display("[TB] FAIL done_sr: got %b_%b want %b", aSrQ, bSrQ, exp[7:0]);
        end
        tick();
        obs = {busy, bitValid, carryClr, done, aBit, bBit, bitIdx};
        vectors++;
        if (obs !== 10'b0) begin
            miscompares++;
            $display("[TB] FAIL after_done_idle: got %b want 0000000000", obs);
        end
        for (int c = 0; c < 3; c++) begin
            if (bitValid === 1'b1) validCount++;
            tick();
        end
        vectors++;
        if (validCount !== 4) begin
            miscompares++;
            $display("[TB] FAIL valid_count: got %0d want 4", validCount);
        end
    endtask

    // Start asserted in the DONE cycle chains straight into a new SHIFT.
    task automatic test_back_to_back();
        logic [3:0] aExp;
        logic [3:0] bExp;
        logic [9:0] obs;
        logic [9:0] exp;
        aExp = 4'b1111;
        bExp = 4'b0001;
        start = 1'b1; aIn = 4'b1011; bIn = 4'b0110;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_done: got %b want 1", done);
        end
        start = 1'b1; aIn = aExp; bIn = bExp;
        tick();
        start = 1'b0; aIn = 4'b0; bIn = 4'b0;
        for (int i = 0; i < 4; i++) begin
            obs = {busy, bitValid, carryClr, done, aBit, bBit, bitIdx};
            exp = {1'b1, 1'b1, (i == 0), 1'b0, aExp[i], bExp[i], 4'(i)};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("[TB] FAIL b2b_bit%0d: got %b want %b", i, obs, exp);
            end
            tick();
        end
        vectors++;
        if ({done, busy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL b2b_done: got %b want 10", {done, busy});
        end
        tick();
    endtask

    // Reset while bit 2 is presented aborts with no done pulse and cleared registers.
    task automatic test_reset_mid_shift();
        logic [9:0] obs;
        start = 1'b1; aIn = 4'b1011; bIn = 4'b0110;
        tick();
        start = 1'b0; aIn = 4'b0; bIn = 4'b0;
        tick();
        tick();
        vectors++;
        if ({bitValid, bitIdx} !== 5'b1_0010) begin
            miscompares++;
            $display("[TB] FAIL mid_reach_idx2: got %b want 10010", {bitValid, bitIdx});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        obs = {busy, bitValid, carryClr, done, aBit, bBit, bitIdx};
        vectors++;
        if (obs !== 10'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_outputs: got %b want 0000000000", obs);
        end
        vectors++;
        if ({aSrQ, bSrQ} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_sr: got %h want 00", {aSrQ, bSrQ});
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if ({done, bitValid} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL mid_no_done cycle %0d: got %b want 00", c, {done, bitValid});
            end
        end
    endtask

    // WIDTH=1 instance: one SHIFT cycle with carry_clr, then DONE, then IDLE.
    task automatic test_width1();
        logic [4:0] obs;
        start1 = 1'b1; aIn1 = 1'b1; bIn1 = 1'b0;
        tick();
        start1 = 1'b0; aIn1 = 1'b0;
        obs = {busy1, bitValid1, carryClr1, aBit1, bBit1};
        vectors++;
        if (obs !== 5'b11110 || bitIdx1 !== 4'd0 || done1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL w1_shift: got %b idx %0d done %b want 11110 idx 0 done 0", obs, bitIdx1, done1);
        end
        tick();
        vectors++;
        if ({done1, busy1, bitValid1, carryClr1} !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL w1_done: got %b want 1000", {done1, busy1, bitValid1, carryClr1});
        end
        vectors++;
        if ({aSrQ1, bSrQ1} !== (RECIRC ? 2'b10 : 2'b00)) begin
            miscompares++;
            $display("[TB] FAIL w1_sr: got %b want %b", {aSrQ1, bSrQ1}, (RECIRC ? 2'b10 : 2'b00));
        end
        tick();
        vectors++;
        if ({done1, busy1, bitValid1} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL w1_idle: got %b want 000", {done1, busy1, bitValid1});
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        start = 1'b0;  aIn = 4'b0;  bIn = 4'b0;
        start1 = 1'b0; aIn1 = 1'b0; bIn1 = 1'b0;
        #2;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_back_to_back();
        test_reset_mid_shift();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_operand_shifter.md
Name: serial_operand_shifter

Overview:
- Parallel-in/serial-out operand feeder directly upstream of the serial adder's full-adder and carry flip-flop.
- Loads two WIDTH-bit operands on a start strobe, then presents one LSB-first bit pair per clock.
- Drives the carry flip-flop's enable (bit_valid) and a carry-clear strobe for the first bit.
- Signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8: operand width in bits; legal range 1..15.
- CNT_W, 4: bit-index counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  load request; sampled on rising edge of clk.
- a_in  input  WIDTH  operand A, captured when start accepted.
- b_in  input  WIDTH  operand B, captured when start accepted.
- a_bit  output  1  current serial bit of A (LSB first).
- b_bit  output  1  current serial bit of B (LSB first).
- bit_valid  output  1  a_bit/b_bit valid; connects to the carry flip-flop enable.
- carry_clr  output  1  high with bit 0 only; downstream clears carry.
- bit_idx  output  CNT_W  index of the bit currently presented.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse after the last bit.
- a_sr_q  output  WIDTH  A shift-register contents (debug/verification).
- b_sr_q  output  WIDTH  B shift-register contents (debug/verification).

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, and named reset.
- State machine: IDLE, SHIFT, DONE. All outputs are Moore (decoded from state and registers).
- Reset, sampled at a clk edge, sets:
  - state=IDLE, a_sr=b_sr=0, cnt=0.
  - All outputs 0.
  - Reset has priority over start.
- IDLE:
  - busy=0, bit_valid=0, done=0, a_bit=b_bit=0.
  - start=1 at edge: a_sr<=a_in, b_sr<=b_in, cnt<=0, state<=SHIFT.
- SHIFT:
  - Outputs: busy=1, bit_valid=1, a_bit=a_sr[0], b_bit=b_sr[0], bit_idx=cnt, carry_clr=(cnt==0).
  - Each edge: a_sr, b_sr shift right by one (MSB fill per Optional Feature); cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: state<=DONE, cnt<=0.
  - start is ignored during SHIFT; operands are not reloaded.
- DONE:
  - Outputs: done=1, busy=0, bit_valid=0, a_bit=b_bit=0.
  - Next edge: start=1 performs a load and goes directly to SHIFT (back-to-back, no idle bubble); otherwise IDLE.
- Latency:
  - start accepted at edge k.
  - Bit i is presented in the cycle after edge k+i, for i=0..WIDTH-1.
  - done is high in the cycle after edge k+WIDTH.
  - Exactly WIDTH bit_valid cycles per operation.
- Boundary conditions:
  - WIDTH=1: a single SHIFT cycle with carry_clr=1 and bit_valid=1, then DONE.
  - Reset mid-SHIFT: aborts immediately, no done pulse, registers cleared.
  - Reset and start together: reset wins; state remains IDLE.
  - bit_idx is 0 outside SHIFT.
  - cnt never exceeds WIDTH-1.

Optional Feature:
- Macro: SERIAL_SHIFTER_RECIRC_EN.
- Defined: right rotate; a_sr[WIDTH-1]<=a_sr[0], same for B. After done, a_sr_q/b_sr_q equal the loaded operands.
- Undefined: zero fill. After done, a_sr_q=b_sr_q=0.
- Serial bit streams are identical in both builds.

Test Plan:
- Reset with start=1 held for 2 cycles, WIDTH=4 -> state stays IDLE; all outputs 0; no bit_valid.
- WIDTH=4, a_in=4'b1011, b_in=4'b0110, 1-cycle start:
  - a_bit 1,1,0,1 and b_bit 0,1,1,0 over 4 consecutive bit_valid cycles.
  - carry_clr only on the first cycle; bit_idx 0..3.
  - done exactly one cycle later.
- Pulse start again during SHIFT with different operands -> ignored; bit stream unchanged; exactly 4 bit_valid cycles.
- start asserted in the DONE cycle with a_in=4'b1111, b_in=4'b0001 -> SHIFT starts next cycle with no IDLE gap; a_bit 1,1,1,1; b_bit 1,0,0,0.
- Assert reset during bit_idx=2 -> next cycle all outputs 0; no done pulse; a_sr_q=b_sr_q=0.
- Build with and without SERIAL_SHIFTER_RECIRC_EN, load a_in=4'b1011, b_in=4'b0110 -> after done, a_sr_q=4'b1011 and b_sr_q=4'b0110 (defined) vs 4'b0000 (undefined); serial streams identical.
